// File: rtl/mod3_frame_tx_pkg.sv
// Shared definitions for serial mod-3 framing: FSM encodings plus the
// per-bit residue step and check-bit mapping used by tx and checker blocks.
package mod3_frame_tx_pkg;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] DATA = 2'b01;
   localparam logic [1:0] CHK1 = 2'b10;
   localparam logic [1:0] CHK0 = 2'b11;

   // Next residue after shifting in bit b: (2r + b) mod 3.
   function automatic logic [1:0] residue_step(input logic [1:0] r, input logic b);
      logic [1:0] n;
      case (r)
         2'd0:    n = b ? 2'd1 : 2'd0;
         2'd1:    n = b ? 2'd0 : 2'd2;
         2'd2:    n = b ? 2'd2 : 2'd1;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

   // Two trailing bits c = (3 - r) mod 3 that make 4*word + c divisible by 3.
   function automatic logic [1:0] check_bits(input logic [1:0] r);
      logic [1:0] c;
      case (r)
         2'd1:    c = 2'b10;
         2'd2:    c = 2'b01;
         default: c = 2'b00;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mod3_frame_tx.sv
// Serial frame transmitter: W data bits MSB first, then two check bits that
// make the whole frame value divisible by 3. Frames may run back-to-back.
module mod3_frame_tx
   import mod3_frame_tx_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] data_in,
   input  logic         load,
   output logic         ready,
   output logic         sout,
   output logic         sout_valid,
   output logic         frame_last
);

   localparam int CNT_W = $clog2(W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

   logic [1:0]       state_q, state_d;
   logic [W-1:0]     shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       res_q, res_d;
   logic             accept;
   logic [1:0]       chk;

   assign ready  = (state_q == IDLE) || (state_q == CHK0);
   assign accept = load && ready;
   assign chk    = check_bits(res_q);

   always_comb begin
      // NOTE: every signal gets a hold default first, so no path leaves one unassigned and no latch is inferred.
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         DATA: begin
            shift_d = {shift_q[W-2:0], 1'b0};
            res_d   = residue_step(res_q, shift_q[W-1]);
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) state_d = CHK1;
         end
         CHK1:    state_d = CHK0;
         CHK0:    state_d = IDLE;
         default: ;
      endcase
      // Acceptance in CHK0 overrides the return to IDLE for gapless frames.
      if (accept) begin
         state_d = DATA;
         shift_d = data_in;
         cnt_d   = '0;
         res_d   = '0;
      end
   end

   // NOTE: the residue and shift register are cleared by reset too, so a frame abandoned mid-way leaves nothing behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         // NOTE: non-blocking updates keep every flop sampling the pre-edge values.
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      sout = 1'b0;
      case (state_q)
         DATA:    sout = shift_q[W-1];
         CHK1:    sout = chk[1];
         CHK0:    sout = chk[0];
         default: sout = 1'b0;
      endcase
   end

   assign sout_valid = (state_q != IDLE);
   assign frame_last = (state_q == CHK0);

endmodule
